altsyncram_rdstream: RTL and testbench

Read-side streaming engine that sits directly downstream of an `altsyncram` read port (port B of a DUAL_PORT / BIDIR_DUAL_PORT instance, or port A of a ROM). On a start command it issues a burst of sequential reads and compensates for the RAM's fixed read latency. Returned words pass through a small credit-tracked FIFO and leave on a valid/ready stream with backpressure. Typical consumers are framebuffer scan-out, ROM-to-peripheral copy and memory-dump-to-host paths in the virtual devboard.

---
 rtl/altsyncram_rdstream.sv | 132 +++++++++++++
 tb/tb_altsyncram_rdstream.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/altsyncram_rdstream.sv
// altsyncram_rdstream: burst reader for an altsyncram read port with latency compensation, credit-tracked FIFO and valid/ready output
// Ports: clock0/aclr0 clock and async active-high reset; start/base_address/length burst command;
//        busy/done status; mem_address/mem_rden/mem_q RAM read port; out_data/out_valid/out_ready/out_last stream.
module altsyncram_rdstream #(
    parameter int width        = 8,
    parameter int widthad      = 10,
    parameter int read_latency = 1,
    parameter int fifo_depth   = 4
) (
    input  logic               clock0,
    input  logic               aclr0,
    input  logic               start,
    input  logic [widthad-1:0] base_address,
    input  logic [widthad:0]   length,
    output logic               busy,
    output logic               done,
    output logic [widthad-1:0] mem_address,
    output logic               mem_rden,
    input  logic [width-1:0]   mem_q,
    output logic [width-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last
);
    localparam int aw = $clog2(fifo_depth);
    localparam int cw = aw + 3;
    localparam logic [widthad:0] one = 1;

    generate
        if (read_latency != 1 && read_latency != 2) begin : g_bad_latency
            $error("altsyncram_rdstream: read_latency must be 1 or 2");
        end
        if (fifo_depth < read_latency + 1 || (fifo_depth & (fifo_depth - 1)) != 0) begin : g_bad_depth
            $error("altsyncram_rdstream: fifo_depth must be a power of 2 and at least read_latency+1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state;

    logic [widthad-1:0]    nxt;
    logic [widthad:0]      remaining, delivered;
    logic [read_latency-1:0] pipe;
    logic [width-1:0]      fifo [fifo_depth];
    logic [aw-1:0]         wr_ptr, rd_ptr;
    logic [aw:0]           count;
    logic [cw-1:0]         occ;
    logic                  push, pop, credit;

    assign push      = pipe[read_latency-1];
    assign out_valid = count != '0;
    assign pop       = out_valid & out_ready;
    assign out_data  = fifo[rd_ptr];
    assign out_last  = out_valid && delivered == one;

    // Occupancy after this edge if nothing new is issued: every read still
    // travelling (the one on mem_rden plus the valid pipe) lands in the FIFO,
    // and a pop this edge frees a slot. Issuing is safe only if that leaves room.
    always_comb begin
        occ = cw'(count) + cw'(mem_rden) - cw'(pop);
        for (int i = 0; i < read_latency; i++) occ = occ + cw'(pipe[i]);
        credit = occ < cw'(fifo_depth);
    end

    always_ff @(posedge clock0 or posedge aclr0) begin
        if (aclr0) begin
            pipe   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < fifo_depth; i++) fifo[i] <= '0;
        end else begin
            pipe <= read_latency'({pipe, mem_rden});
            if (push) begin
                fifo[wr_ptr] <= mem_q;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (aw+1)'(push) - (aw+1)'(pop);
        end
    end

    always_ff @(posedge clock0 or posedge aclr0) begin
        if (aclr0) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_rden    <= 1'b0;
            mem_address <= '0;
            nxt         <= '0;
            remaining   <= '0;
            delivered   <= '0;
        end else begin
            mem_rden <= 1'b0;
            done     <= 1'b0;
            if (pop) delivered <= delivered - 1'b1;
            case (state)
                IDLE: if (start) begin
                    busy      <= 1'b1;
                    delivered <= length;
                    if (length == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        // first read goes out on the start edge itself
                        mem_rden    <= 1'b1;
                        mem_address <= base_address;
                        nxt         <= base_address + 1'b1;
                        remaining   <= length - 1'b1;
                        state       <= length == one ? DRAIN : ISSUE;
                    end
                end
                ISSUE: if (credit) begin
                    mem_rden    <= 1'b1;
                    mem_address <= nxt;
                    nxt         <= nxt + 1'b1;
                    remaining   <= remaining - 1'b1;
                    if (remaining == one) state <= DRAIN;
                end
                DRAIN: if (pop && out_last) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_altsyncram_rdstream.sv
// tb_altsyncram_rdstream: drives a latency-1 and a latency-2 instance with identical bursts and scoreboards both streams
module tb_altsyncram_rdstream;
    localparam int W  = 16;
    localparam int AW = 10;

    logic          clock0 = 1'b0;
    logic          aclr0 = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b1;
    logic [AW-1:0] base_address = '0;
    logic [AW:0]   length = '0;

    logic          busy [2], done [2], rden [2], valid [2], last [2];
    logic [AW-1:0] addr [2];
    logic [W-1:0]  q [2], data [2];
    logic [W-1:0]  q_stage;
    logic [W-1:0]  ram [1 << AW];

    logic [W:0]    exp [2][$];
    int            iss [2], pops [2], dones [2], first_pop [2], last_pop [2];
    int            iss_b [2], pops_b [2], dones_b [2];
    logic          pv [2], pr [2];
    logic [W-1:0]  pd [2];
    int            cyc = 0, start_cyc = 0;
    int            tests = 0, fails = 0;

    always #5 clock0 = ~clock0;
    always @(posedge clock0) cyc <= cyc + 1;

    altsyncram_rdstream #(.width(W), .widthad(AW), .read_latency(1), .fifo_depth(4)) u_lat1 (
        .clock0(clock0), .aclr0(aclr0), .start(start), .base_address(base_address), .length(length),
        .busy(busy[0]), .done(done[0]), .mem_address(addr[0]), .mem_rden(rden[0]), .mem_q(q[0]),
        .out_data(data[0]), .out_valid(valid[0]), .out_ready(out_ready), .out_last(last[0]));

    altsyncram_rdstream #(.width(W), .widthad(AW), .read_latency(2), .fifo_depth(4)) u_lat2 (
        .clock0(clock0), .aclr0(aclr0), .start(start), .base_address(base_address), .length(length),
        .busy(busy[1]), .done(done[1]), .mem_address(addr[1]), .mem_rden(rden[1]), .mem_q(q[1]),
        .out_data(data[1]), .out_valid(valid[1]), .out_ready(out_ready), .out_last(last[1]));

    // RAM models: unregistered output (1 clock) and registered output (2 clocks)
    always @(posedge clock0) begin
        if (rden[0]) q[0] <= ram[addr[0]];
        if (rden[1]) q_stage <= ram[addr[1]];
        q[1] <= q_stage;
    end

    always @(negedge clock0) begin
        for (int i = 0; i < 2; i++) begin
            if (aclr0) begin
                exp[i].delete();
                pv[i] = 1'b0;
            end else begin
                if (rden[i]) iss[i]++;
                if (done[i]) dones[i]++;
                if (pv[i] && !pr[i]) begin
                    tests++;
                    assert (valid[i] === 1'b1 && data[i] === pd[i]) else begin
                        fails++;
                        $error("FAIL stall_hold dut%0d: observed valid=%0b data=%h expected valid=1 data=%h", i, valid[i], data[i], pd[i]);
                    end
                end
                if (valid[i] && out_ready) begin
                    pops[i]++;
                    if (pops[i] - pops_b[i] == 1) first_pop[i] = cyc;
                    last_pop[i] = cyc;
                    tests++;
                    assert (exp[i].size() != 0) else begin
                        fails++;
                        $error("FAIL extra_word dut%0d: observed data=%h with no word expected", i, data[i]);
                    end
                    if (exp[i].size() != 0) begin
                        logic [W:0] e;
                        e = exp[i].pop_front();
                        tests++;
                        assert ({last[i], data[i]} === e) else begin
                            fails++;
                            $error("FAIL word dut%0d: observed last=%0b data=%h expected last=%0b data=%h", i, last[i], data[i], e[W], e[W-1:0]);
                        end
                    end
                end
                tests++;
                assert ((iss[i] - iss_b[i]) - (pops[i] - pops_b[i]) <= 4) else begin
                    fails++;
                    $error("FAIL credit dut%0d: observed %0d outstanding expected <= 4", i, (iss[i] - iss_b[i]) - (pops[i] - pops_b[i]));
                end
                pv[i] = valid[i];
                pr[i] = out_ready;
                pd[i] = data[i];
            end
        end
    end

    task automatic tick();
        @(posedge clock0);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic burst(input logic [AW-1:0] b, input logic [AW:0] n);
        base_address = b;
        length = n;
        start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            iss_b[i] = iss[i];
            pops_b[i] = pops[i];
            dones_b[i] = dones[i];
            for (int k = 0; k < int'(n); k++) begin
                logic [AW-1:0] a;
                a = b + AW'(k);
                exp[i].push_back({k == int'(n) - 1, W'(a)});
            end
        end
        tick();
        start = 1'b0;
        start_cyc = cyc;
    endtask

    // mode 1 drives out_ready in a repeating 1-0-0-1 pattern
    task automatic wait_idle(input string tag, input int mode, input int budget);
        int k = 0;
        while ((busy[0] || busy[1]) && k < budget) begin
            out_ready = mode == 0 || k % 4 == 0 || k % 4 == 3;
            tick();
            k++;
        end
        out_ready = 1'b1;
        check({tag, "_timeout"}, k < budget, 1);
    endtask

    task automatic end_checks(input string tag, input int n);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_done%0d", tag, i), dones[i] - dones_b[i], 1);
            check($sformatf("%s_reads%0d", tag, i), iss[i] - iss_b[i], n);
            check($sformatf("%s_words%0d", tag, i), pops[i] - pops_b[i], n);
            check($sformatf("%s_left%0d", tag, i), exp[i].size(), 0);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = W'(i);
        repeat (2) tick();
        for (int i = 0; i < 2; i++)
            check($sformatf("reset_outputs%0d", i), {busy[i], done[i], rden[i], valid[i], last[i], addr[i], data[i]}, 0);
        aclr0 = 1'b0;
        tick();

        // plain burst: first read on the start edge, first word L+1 clocks after it, back-to-back words
        burst(10'h010, 11'd8);
        check("t1_busy", busy[0], 1);
        check("t1_rden", rden[0], 1);
        check("t1_addr", addr[0], 32'h10);
        wait_idle("t1", 0, 60);
        check("t1_latency_l1", first_pop[0] - start_cyc, 2);
        check("t1_latency_l2", first_pop[1] - start_cyc, 3);
        check("t1_rate_l1", last_pop[0] - first_pop[0], 7);
        check("t1_rate_l2", last_pop[1] - first_pop[1], 7);
        end_checks("t1", 8);
        tick();

        // address wrap at the top of the RAM
        burst(10'h3FE, 11'd4);
        wait_idle("t2", 0, 60);
        check("t2_rate_l2", last_pop[1] - first_pop[1], 3);
        end_checks("t2", 4);
        tick();

        // backpressure in a 1-0-0-1 pattern
        burst(10'h100, 11'd16);
        wait_idle("t3", 1, 200);
        end_checks("t3", 16);
        tick();

        // zero-length burst finishes at once with no traffic
        burst(10'h055, 11'd0);
        wait_idle("t4", 0, 4);
        end_checks("t4", 0);
        tick();

        // start while busy is ignored
        burst(10'h200, 11'd6);
        tick();
        base_address = 10'h300;
        length = 11'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("t5", 0, 60);
        end_checks("t5", 6);
        tick();

        // reset in the middle of a burst, then a short clean burst
        burst(10'h000, 11'd32);
        begin
            int k = 0;
            while (pops[0] - pops_b[0] < 4 && k < 50) begin
                tick();
                k++;
            end
            check("t6_reach_word5", k < 50, 1);
        end
        aclr0 = 1'b1;
        #1;
        for (int i = 0; i < 2; i++)
            check($sformatf("t6_reset_outputs%0d", i), {busy[i], done[i], rden[i], valid[i], last[i], addr[i], data[i]}, 0);
        tick();
        aclr0 = 1'b0;
        tick();
        burst(10'h02A, 11'd2);
        wait_idle("t6", 0, 60);
        end_checks("t6", 2);
        tick();

        // whole RAM in one burst
        burst(10'h000, 11'd1024);
        wait_idle("t7", 0, 1200);
        check("t7_rate_l1", last_pop[0] - first_pop[0], 1023);
        end_checks("t7", 1024);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish before 1ms");
        $fatal(1);
    end
endmodule
